// File: rtl/dp_trace_checker.sv
// rtl/dp_trace_checker.sv - self-checking run controller for the MIPS datapath
//
// Drives run for SKIP+DEPTH cycles, registers ds_in on every RUN-phase
// sampling edge and compares it one cycle later against a preloaded table.
// Optional macro TRACE_CAPTURE_EN adds a capture buffer of RUN samples.
//
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   start            pulse; begins a run from IDLE or DONE
//   exp_we/addr/data expected-table write port (ignored while busy)
//   ds_in            datapath output word
//   run              datapath enable
//   busy, done, pass status; pass valid while done
//   err_count        number of mismatches
//   first_err_idx    index of the first mismatch
//   first_err_data   ds_in value at the first mismatch
//   cap_addr/cap_data (TRACE_CAPTURE_EN only) combinational capture readback
module dp_trace_checker #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int SKIP  = 0,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             exp_we,
  input  logic [AW-1:0]    exp_addr,
  input  logic [WIDTH-1:0] exp_data,
  input  logic [WIDTH-1:0] ds_in,
`ifdef TRACE_CAPTURE_EN
  input  logic [AW-1:0]    cap_addr,
  output logic [WIDTH-1:0] cap_data,
`endif
  output logic             run,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [AW:0]      err_count,
  output logic [AW-1:0]    first_err_idx,
  output logic [WIDTH-1:0] first_err_data
);

  localparam int CW = $clog2(SKIP + 2);
  localparam logic [AW:0] ERR_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic             launch;
  logic             sample;
  logic             mismatch;
  logic [CW-1:0]    fill_cnt;
  logic [AW-1:0]    idx;
  logic [AW-1:0]    q_idx;
  logic             q_vld;
  logic [WIDTH-1:0] ds_q;
  logic [WIDTH-1:0] exp_mem [DEPTH];

  assign busy = (state == S_FILL) || (state == S_RUN);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == '0);

  // Sampling edges are RUN-state edges except the final one, which only
  // retires the last registered compare before moving to DONE.
  assign sample   = (state == S_RUN) && (state_nxt == S_RUN);
  assign mismatch = q_vld && (ds_q != exp_mem[q_idx]);

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          launch    = 1'b1;
          state_nxt = (SKIP > 0) ? S_FILL : S_RUN;
        end
      end
      S_FILL: begin
        if (fill_cnt == CW'(SKIP - 1)) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (q_vld && (q_idx == AW'(DEPTH - 1))) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= S_IDLE;
      run            <= 1'b0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      fill_cnt       <= '0;
      idx            <= '0;
      q_idx          <= '0;
      q_vld          <= 1'b0;
      ds_q           <= '0;
    end else begin
      state <= state_nxt;
      // run lags busy by one cycle so it rises one edge after start and
      // falls on the same edge that done rises.
      run   <= busy && ((state_nxt == S_FILL) || (state_nxt == S_RUN));
      q_vld <= sample;
      if (launch) begin
        err_count      <= '0;
        first_err_idx  <= '0;
        first_err_data <= '0;
        fill_cnt       <= '0;
        idx            <= '0;
      end else begin
        if (state == S_FILL) fill_cnt <= fill_cnt + CNT_ONE;
        if (sample) begin
          ds_q  <= ds_in;
          q_idx <= idx;
          idx   <= idx + IDX_ONE;
        end
        if (mismatch) begin
          err_count <= err_count + ERR_ONE;
          if (err_count == '0) begin
            first_err_idx  <= q_idx;
            first_err_data <= ds_q;
          end
        end
      end
    end
  end

  // Table survives reset and is frozen while a run is in progress.
  always_ff @(posedge CLK) begin
    if (exp_we && !busy) exp_mem[exp_addr] <= exp_data;
  end

`ifdef TRACE_CAPTURE_EN
  logic [WIDTH-1:0] cap_mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (sample) cap_mem[idx] <= ds_in;
  end

  assign cap_data = cap_mem[cap_addr];
`endif

endmodule

// File: doc/dp_trace_checker.md
# dp_trace_checker

Self-checking run controller for the MIPS datapath. It drives the datapath's run enable for a fixed number of clock cycles and samples the datapath output bus (DS) on each active cycle. Each sample is compared against a preloaded table of expected words, and the block reports pass/fail, the error count and the first mismatch. It replaces fixed-delay, unchecked clock-stepping benches and can also be instantiated on-chip as a built-in self-test monitor.

## Interface
Parameters:
- WIDTH, 32, width of the datapath output word.
- DEPTH, 16, number of compared cycles; also the expected-table depth (≥2).
- SKIP, 0, cycles of run asserted before comparison starts (pipeline fill).
- AW, $clog2(DEPTH), table address width.

Ports:
- CLK  in  1  single clock; all logic on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- start  in  1  pulse; begins a run from IDLE or DONE.
- exp_we  in  1  expected-table write enable.
- exp_addr  in  AW  expected-table write address.
- exp_data  in  WIDTH  expected-table write data.
- ds_in  in  WIDTH  datapath output (DS).
- run  out  1  datapath enable.
- busy  out  1  high in FILL or RUN.
- done  out  1  high in DONE.
- pass  out  1  valid when done is high; 1 means zero mismatches.
- err_count  out  AW+1  number of mismatches.
- first_err_idx  out  AW  index of the first mismatch.
- first_err_data  out  WIDTH  ds_in value captured at the first mismatch.

## Operation
- States: IDLE → FILL → RUN → DONE.
- IDLE:
  - start=1 → FILL if SKIP>0, otherwise RUN.
  - Entering FILL or RUN clears err_count, first_err_*, and the cycle and index counters.
- FILL:
  - run=1; no comparison.
  - After SKIP cycles → RUN.
- RUN:
  - run=1. Each cycle, compare ds_in with exp[idx], then idx++.
  - On a mismatch, err_count++. If this is the first mismatch, latch idx into first_err_idx and ds_in into first_err_data.
  - After the compare at idx=DEPTH-1 → DONE.
- DONE:
  - run=0; done=1; pass=(err_count==0).
  - Outputs hold until start or RST. start=1 restarts exactly as from IDLE.
- Expected table:
  - DEPTH×WIDTH array, written when exp_we=1.
  - Writes are ignored while busy=1 (the table is frozen during a run).
  - Not cleared by RST.
- start while busy=1 is ignored.
- err_count maximum is DEPTH, so it cannot overflow.

## Timing
- Reset values: state=IDLE; run=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, first_err_data=0.
- RST during any state:
  - Returns to IDLE on the same edge.
  - The partial result is discarded.
  - run deasserts on the next cycle boundary.
- start sampled at edge t → run=1 from t+1.
- run stays high for exactly SKIP+DEPTH cycles.
- The RUN sample for index k is ds_in at edge t+1+SKIP+k.
- done and pass rise at edge t+1+SKIP+DEPTH; run falls on that same edge.
- The comparison uses ds_in registered on the sampling edge. The err_count update for index k is visible one cycle after that sample (registered output).
- Simultaneous exp_we and start in IDLE: the write takes effect, and the run reads the new value if the address is ≥ the first compared index. Writes complete in one edge, so the written value is available by the compare.
- Simultaneous RST and start: RST wins.

## Configuration
- TRACE_CAPTURE_EN:
  - Defined:
    - Adds a DEPTH×WIDTH capture buffer that stores every RUN-phase ds_in sample at its idx.
    - Adds ports cap_addr (in, AW) and cap_data (out, WIDTH). cap_data is a combinational read of the buffer.
    - The buffer is not reset and keeps the last run's contents until the next run overwrites them.
  - Undefined:
    - No buffer and no cap_* ports.
    - Comparison behaviour is identical.

## Test plan
- Matching run:
  - Stimulus: DEPTH=16, SKIP=0; load exp[k]=k×4; drive ds_in=k×4 on each RUN sample; pulse start.
  - Response: run high for 16 cycles; done=1 at start+17; pass=1; err_count=0.
- Injected errors:
  - Stimulus: same setup, but ds_in=0xDEADBEEF at k=5 and at k=11.
  - Response: pass=0; err_count=2; first_err_idx=5; first_err_data=0xDEADBEEF.
- Pipeline fill:
  - Stimulus: SKIP=3; ds_in garbage for the first 3 run cycles, then matching values.
  - Response: pass=1; run high for 19 cycles.
- Reset mid-run:
  - Stimulus: assert RST at RUN idx=7.
  - Response: next cycle run=0, done=0, err_count=0, state IDLE. A following start produces a full 16-cycle run.
- Busy protections:
  - Stimulus: during RUN, write exp_we to address 15 with 0x1; also pulse start.
  - Response: table unchanged, so pass is unaffected; start is ignored; run length remains 16.
- Capture readback (TRACE_CAPTURE_EN defined): after the injected-error run, cap_addr=5 → cap_data=0xDEADBEEF; cap_addr=6 → 0x18.
